// File: rtl/soc_system_freq_divider.sv
// Multi-channel programmable frequency divider behind an Avalon-MM slave.
// Each channel emits a terminal-count tick and a 50%-duty divided waveform.

module soc_system_freq_divider_ch #(
    parameter int          CNT_WIDTH = 32,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 ctrl_wr,
    input  logic                 ctrl_bit,
    input  logic [CNT_WIDTH-1:0] shadow_next,
    output logic                 tick,
    output logic                 clk_out,
    output logic                 running
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            active  <= CNT_WIDTH'(DIV_RESET);
        end else if (ctrl_wr && !ctrl_bit) begin
            // a disabling CTRL write overrides any terminal count this cycle
            state   <= IDLE;
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            active  <= shadow_next;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    tick    <= 1'b0;
                    clk_out <= 1'b0;
                    active  <= shadow_next;
                    if ((ctrl_wr || en) && shadow_next != '0)
                        state <= RUN;
                end
                default: begin
                    if (cnt == active - ONE) begin
                        // divisor changes only at period boundaries to stay glitch-free
                        cnt     <= '0;
                        tick    <= 1'b1;
                        clk_out <= ~clk_out;
                        active  <= shadow_next;
                        if (shadow_next == '0)
                            state <= IDLE;
                    end else begin
                        cnt  <= cnt + ONE;
                        tick <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign running = (state == RUN);
endmodule

module soc_system_freq_divider #(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_WIDTH  = 32,
    parameter int          ADDR_WIDTH = 3,
    parameter int unsigned DIV_RESET  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [NUM_CH-1:0]     tick,
    output logic [NUM_CH-1:0]     clk_out
);
    logic                              wr;
    logic                              ctrl_wr;
    logic [NUM_CH-1:0]                 ctrl;
    logic [NUM_CH-1:0]                 running;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]  shadow;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]  shadow_next;

    assign wr      = chipselect && !write_n;
    assign ctrl_wr = wr && (address == '0);

    always_ff @(posedge clk) begin
        if (reset)        ctrl <= '0;
        else if (ctrl_wr) ctrl <= writedata[NUM_CH-1:0];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [ADDR_WIDTH-1:0] DIV_ADDR = ADDR_WIDTH'(i + 2);

        assign shadow_next[i] = (wr && address == DIV_ADDR) ? writedata[CNT_WIDTH-1:0] : shadow[i];

        always_ff @(posedge clk) begin
            if (reset) shadow[i] <= CNT_WIDTH'(DIV_RESET);
            else       shadow[i] <= shadow_next[i];
        end

        soc_system_freq_divider_ch #(
            .CNT_WIDTH (CNT_WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .en          (ctrl[i]),
            .ctrl_wr     (ctrl_wr),
            .ctrl_bit    (writedata[i]),
            .shadow_next (shadow_next[i]),
            .tick        (tick[i]),
            .clk_out     (clk_out[i]),
            .running     (running[i])
        );
    end

    always_comb begin
        readdata = '0;
        if (address == '0) begin
            readdata[NUM_CH-1:0] = ctrl;
        end else if (address == ADDR_WIDTH'(1)) begin
            readdata[NUM_CH-1:0]  = clk_out;
            readdata[8 +: NUM_CH] = running;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (address == ADDR_WIDTH'(i + 2))
                readdata[CNT_WIDTH-1:0] = shadow[i];
    end
endmodule

// File: tb/tb_soc_system_freq_divider.sv
// Scoreboard bench for soc_system_freq_divider: per-cycle expected tick/clk_out
// vectors are queued with each stimulus and popped as the outputs are sampled.

module tb_soc_system_freq_divider;
    localparam int NUM_CH = 4;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [AW-1:0]     address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string             tag;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] clk;
    } exp_t;
    exp_t sb[$];

    soc_system_freq_divider #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(32), .ADDR_WIDTH(AW), .DIV_RESET(0)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .tick(tick), .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] c);
        exp_t e;
        e.tag = tag; e.tick = t; e.clk = c;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_tick"}, 32'(tick), 32'(e.tick));
            chk({e.tag, "_clk"},  32'(clk_out), 32'(e.clk));
        end
    endtask

    task automatic run_cmp(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pop_cmp();
        end
    endtask

    // called 1ns after a rising edge; returns 1ns after the write edge
    task automatic bus_wr(input logic [AW-1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; #1;
        chk(tag, readdata, exp);
        chipselect = 1'b0; address = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic c;
        logic t;

        // reset state
        do_reset();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk", 32'(clk_out), 32'd0);
        rd("rst_ctrl", 3'd0, 32'd0);
        rd("rst_status", 3'd1, 32'd0);
        for (int i = 0; i < NUM_CH; i++) rd("rst_div", AW'(i + 2), 32'd0);

        // ch0 DIV=4
        bus_wr(3'd2, 32'd4);
        rd("div0_rb", 3'd2, 32'd4);
        bus_wr(3'd0, 32'd1);
        for (int k = 0; k <= 20; k++)
            push("t2", {3'b0, k > 0 && k % 4 == 0}, {3'b0, 1'((k / 4) % 2)});
        pop_cmp();
        rd("t2_status0", 3'd1, 32'h100);
        run_cmp(20);
        rd("t2_status20", 3'd1, 32'h101);

        // ch1 DIV=1, ch2 DIV=3, ch0 disabled by the same CTRL write
        bus_wr(3'd3, 32'd1);
        bus_wr(3'd4, 32'd3);
        bus_wr(3'd0, 32'd6);
        for (int k = 0; k <= 15; k++)
            push("t3", {1'b0, k > 0 && k % 3 == 0, k > 0, 1'b0},
                       {1'b0, 1'((k / 3) % 2), 1'(k % 2), 1'b0});
        pop_cmp();
        run_cmp(15);
        rd("t3_ctrl", 3'd0, 32'd6);

        // divisor change mid-period on ch0
        do_reset();
        bus_wr(3'd2, 32'd10);
        bus_wr(3'd0, 32'd1);
        c = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            t = (k == 10) || (k == 20) || (k > 20 && k % 2 == 0);
            if (t) c = ~c;
            push("t4", {3'b0, t}, {3'b0, c});
        end
        pop_cmp();
        run_cmp(13);
        bus_wr(3'd2, 32'd2);
        pop_cmp();
        rd("t4_div_rb", 3'd2, 32'd2);
        run_cmp(16);

        // disable on the terminal-count cycle
        do_reset();
        bus_wr(3'd2, 32'd4);
        bus_wr(3'd0, 32'd1);
        for (int k = 0; k <= 11; k++)
            push("t5", {3'b0, k > 0 && k % 4 == 0}, {3'b0, 1'((k / 4) % 2)});
        for (int k = 12; k <= 15; k++) push("t5_off", '0, '0);
        pop_cmp();
        run_cmp(11);
        bus_wr(3'd0, 32'd0);
        pop_cmp();
        rd("t5_status", 3'd1, 32'd0);
        run_cmp(3);

        // unmapped addresses
        bus_wr(3'd2, 32'd7);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_wr(3'd7, 32'hFFFF_FFFF);
        rd("t6_rd6", 3'd6, 32'd0);
        rd("t6_rd7", 3'd7, 32'd0);
        rd("t6_ctrl", 3'd0, 32'd0);
        rd("t6_div0", 3'd2, 32'd7);
        rd("t6_div3", 3'd5, 32'd0);

        // reset while running
        bus_wr(3'd2, 32'd1);
        bus_wr(3'd0, 32'd1);
        for (int k = 0; k <= 3; k++) push("t6_run", {3'b0, k > 0}, {3'b0, 1'(k % 2)});
        pop_cmp();
        run_cmp(3);
        reset = 1'b1;
        push("t6_rst", '0, '0);
        @(posedge clk); #1;
        pop_cmp();
        reset = 1'b0;
        rd("t6_rst_ctrl", 3'd0, 32'd0);
        rd("t6_rst_div0", 3'd2, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
